// File: rtl/gfx_mem_arbiter_n.sv
// gfx_mem_arbiter_n: single-port graphics RAM arbiter.
//
// Clients are one data fetcher and NUM_ENG drawing engines. The fetcher owns
// a priority slot every DF_PERIOD cycles. Engines share the remaining
// bandwidth through work-conserving round-robin. Grants are registered, and
// the winning command is registered onto the mem_* port. Each read carries a
// one-hot tag down a shift pipeline, so the broadcast return can be claimed
// by its requester (bit0 = fetcher, bit i+1 = engine i).
//
// Optional build macro GFX_ARB_BCAST_REG_EN: when defined, bcast_data_o is
// registered from mem_data_in_i. The tag is then delayed one extra cycle so
// that tag and data stay aligned.
module gfx_mem_arbiter_n #(
    parameter int NUM_ENG   = 3,
    parameter int ADDR_W    = 17,
    parameter int DATA_W    = 32,
    parameter int RD_LAT    = 2,
    parameter int DF_PERIOD = 2
) (
    input  logic                      clk,
    input  logic                      rst_,
    input  logic [ADDR_W-1:0]         fetch_addr_i,
    input  logic [DATA_W-1:0]         fetch_wrdata_i,
    input  logic [3:0]                fetch_op_i,
    input  logic                      fetch_rts_i,
    output logic                      fetch_rtr_o,
    input  logic [NUM_ENG*ADDR_W-1:0] eng_addr_i,
    input  logic [NUM_ENG*DATA_W-1:0] eng_wrdata_i,
    input  logic [NUM_ENG*4-1:0]      eng_op_i,
    input  logic [NUM_ENG-1:0]        eng_rts_i,
    output logic [NUM_ENG-1:0]        eng_rtr_o,
    output logic [3:0]                mem_wben_o,
    output logic [ADDR_W-1:0]         mem_addr_o,
    output logic [DATA_W-1:0]         mem_data_out_o,
    input  logic [DATA_W-1:0]         mem_data_in_i,
    output logic [DATA_W-1:0]         bcast_data_o,
    output logic [NUM_ENG:0]          bcast_xfc_o
);

    localparam int SLOT_W = (DF_PERIOD > 1) ? $clog2(DF_PERIOD) : 1;
    localparam int PTR_W  = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;
`ifdef GFX_ARB_BCAST_REG_EN
    localparam int TAG_LAST = RD_LAT + 1;
`else
    localparam int TAG_LAST = RD_LAT;
`endif

    // Encode a one-hot engine vector into its index.
    function automatic logic [PTR_W-1:0] onehot_to_idx(input logic [NUM_ENG-1:0] v);
        logic [PTR_W-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_ENG; i++) begin
            r = v[i] ? PTR_W'(i) : r;
        end
        return r;
    endfunction

    // Pick the first requester, searching upward from ptr+1 with wrap-around.
    function automatic logic [NUM_ENG-1:0] rr_pick(input logic [NUM_ENG-1:0] req,
                                                   input logic [PTR_W-1:0]   ptr);
        logic [NUM_ENG-1:0] g;
        logic               found;
        logic [PTR_W-1:0]   idx;
        g     = '0;
        found = 1'b0;
        for (int off = 1; off <= NUM_ENG; off++) begin
            idx    = PTR_W'((int'(ptr) + off) % NUM_ENG);
            g[idx] = g[idx] | (~found & req[idx]);
            found  = found | req[idx];
        end
        return g;
    endfunction

    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [NUM_ENG:0]  grant_q, grant_d;

    logic               fetch_xfc_s;
    logic [NUM_ENG-1:0] eng_xfc_s;
    logic               any_xfc_s;

    logic [3:0]        cmd_op_s;
    logic [ADDR_W-1:0] cmd_addr_s;
    logic [DATA_W-1:0] cmd_data_s;
    logic [NUM_ENG:0]  tag_in_s;

    logic [3:0]        mem_wben_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_data_q;
    logic [NUM_ENG:0]  tag_q [TAG_LAST+1];

    // A transfer needs both request and grant in the same cycle.
    assign fetch_xfc_s = fetch_rts_i & grant_q[0];
    assign eng_xfc_s   = eng_rts_i & grant_q[NUM_ENG:1];
    assign any_xfc_s   = fetch_xfc_s | (|eng_xfc_s);

    // Free-running slot counter, wrapping at DF_PERIOD-1.
    always_comb begin
        slot_d = slot_q;
        if (slot_q == SLOT_W'(DF_PERIOD - 1)) begin
            slot_d = '0;
        end else begin
            slot_d = slot_q + SLOT_W'(1);
        end
    end

    // The round-robin pointer follows only engine transfers.
    always_comb begin
        ptr_d = ptr_q;
        if (|eng_xfc_s) begin
            ptr_d = onehot_to_idx(eng_xfc_s);
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Next grant. slot_d is the slot during which this grant is visible.
    // ptr_d already rotates past an engine that is transferring now.
    always_comb begin
        grant_d = '0;
        if ((slot_d == '0) && fetch_rts_i) begin
            grant_d = {{NUM_ENG{1'b0}}, 1'b1};
        end else begin
            grant_d = {rr_pick(eng_rts_i, ptr_d), 1'b0};
        end
    end

    // Select the payload of the transferring client. The fetcher is the fallback.
    always_comb begin
        cmd_op_s   = fetch_op_i;
        cmd_addr_s = fetch_addr_i;
        cmd_data_s = fetch_wrdata_i;
        for (int i = 0; i < NUM_ENG; i++) begin
            cmd_op_s   = eng_xfc_s[i] ? eng_op_i[i*4 +: 4]          : cmd_op_s;
            cmd_addr_s = eng_xfc_s[i] ? eng_addr_i[i*ADDR_W +: ADDR_W] : cmd_addr_s;
            cmd_data_s = eng_xfc_s[i] ? eng_wrdata_i[i*DATA_W +: DATA_W] : cmd_data_s;
        end
        if (any_xfc_s && (cmd_op_s == 4'b0000)) begin
            tag_in_s = {eng_xfc_s, fetch_xfc_s};
        end else begin
            tag_in_s = '0;
        end
    end

    // Arbitration state: slot counter, round-robin pointer and grant register.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            slot_q  <= '0;
            ptr_q   <= PTR_W'(NUM_ENG - 1);
            grant_q <= '0;
        end else begin
            slot_q  <= slot_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
        end
    end

    // Command register. Write enables last one cycle; address and data hold when idle.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            mem_wben_q <= 4'b0000;
            mem_addr_q <= '0;
            mem_data_q <= '0;
        end else if (any_xfc_s) begin
            mem_wben_q <= cmd_op_s;
            mem_addr_q <= cmd_addr_s;
            mem_data_q <= cmd_data_s;
        end else begin
            mem_wben_q <= 4'b0000;
        end
    end

    // Read-tag shift pipeline. Stage 0 lines up with the issued command.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            for (int i = 0; i <= TAG_LAST; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            tag_q[0] <= tag_in_s;
            for (int i = 1; i <= TAG_LAST; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

`ifdef GFX_ARB_BCAST_REG_EN
    logic [DATA_W-1:0] bcast_data_q;

    // Registered broadcast data, one cycle behind the RAM output.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            bcast_data_q <= '0;
        end else begin
            bcast_data_q <= mem_data_in_i;
        end
    end

    assign bcast_data_o = bcast_data_q;
`else
    assign bcast_data_o = mem_data_in_i;
`endif

    assign fetch_rtr_o    = grant_q[0];
    assign eng_rtr_o      = grant_q[NUM_ENG:1];
    assign mem_wben_o     = mem_wben_q;
    assign mem_addr_o     = mem_addr_q;
    assign mem_data_out_o = mem_data_q;
    assign bcast_xfc_o    = tag_q[TAG_LAST];

endmodule
